// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard controller for the five-stage RV32I core.
//
// Keeps a shadow copy of the E/M/W destination-register state. From that state and the
// instruction currently in D it produces:
//   - the execute-stage operand forwarding selects, and
//   - the stall and flush controls for the F/D/E pipeline registers.
// It covers RAW forwarding from M and W, load-use stalls and taken-branch flushes.
//
// Optional feature macro: HAZARD_MULDIV_EN
//   When the macro is defined, a mul/div instruction occupies E for MUL_LAT cycles.
//   F, D and E are stalled meanwhile.
//   When the macro is undefined, StallE is tied low and MulD is ignored.
//
// Parameters:
//   MUL_LAT     cycles a mul/div occupies E (1..15, 1 = no stall)
//
// Ports:
//   clk         core clock, all state updates on the rising edge
//   rst_n       synchronous active-low reset; outputs are forced while it is low
//   Rs1D/Rs2D   source registers of the instruction in D
//   RdD         destination register of the instruction in D
//   RegWriteD   instruction in D writes RdD
//   ResultSrcD  result select of the instruction in D (2'b01 = load)
//   MulD        instruction in D is mul/div
//   PCSrcE      branch/jump taken, resolved in E
//   ForwardAE/BE  operand select for E: 00 regfile, 01 ResultW, 10 ALUResultM
//   StallF/D/E  hold PC, F/D and D/E registers
//   FlushD/E    clear F/D and D/E registers (insert bubble)

module hazard_unit #(
    parameter int unsigned MUL_LAT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] RdD,
    input  logic       RegWriteD,
    input  logic [1:0] ResultSrcD,
    input  logic       MulD,
    input  logic       PCSrcE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       FlushD,
    output logic       FlushE
);

    localparam logic [3:0] CntLast = 4'(MUL_LAT - 1);

    // Forwarding select values
    localparam logic [1:0] FwdRf = 2'b00;
    localparam logic [1:0] FwdW  = 2'b01;
    localparam logic [1:0] FwdM  = 2'b10;

    // E-stage shadow
    logic [4:0] rs1_e_q, rs1_e_d;
    logic [4:0] rs2_e_q, rs2_e_d;
    logic [4:0] rd_e_q, rd_e_d;
    logic       regwrite_e_q, regwrite_e_d;
    logic       load_e_q, load_e_d;

    // M-stage shadow
    logic [4:0] rd_m_q, rd_m_d;
    logic       regwrite_m_q, regwrite_m_d;

    // W-stage shadow
    logic [4:0] rd_w_q, rd_w_d;
    logic       regwrite_w_q, regwrite_w_d;

    // Unmasked internal controls; the outputs are these gated by reset
    logic       stall_e;
    logic       lw_stall;
    logic       flush_e;
    logic       load_d;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    assign load_d = (ResultSrcD == 2'b01);

`ifdef HAZARD_MULDIV_EN
    logic       mul_e_q, mul_e_d;
    logic [3:0] cnt_q, cnt_d;

    // Hold E until the mul/div has spent its last cycle there
    assign stall_e = mul_e_q && (cnt_q != CntLast);

    always_comb begin
        cnt_d   = 4'd0;
        mul_e_d = mul_e_q;
        if (stall_e) begin
            cnt_d = cnt_q + 4'd1;
        end
        if (flush_e) begin
            mul_e_d = 1'b0;
        end else if (!stall_e) begin
            mul_e_d = MulD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mul_e_q <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            mul_e_q <= mul_e_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    assign stall_e = 1'b0;

    // MulD and the latency setting have no effect in this build
    logic unused_muldiv;
    assign unused_muldiv = ^{MulD, CntLast};
`endif

    // M has priority over W; x0 is hard-wired and never forwards
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       wr_m,
        input logic [4:0] rd_w,
        input logic       wr_w
    );
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            return FwdM;
        end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            return FwdW;
        end
        return FwdRf;
    endfunction

    always_comb begin
        fwd_a = fwd_sel(rs1_e_q, rd_m_q, regwrite_m_q, rd_w_q, regwrite_w_q);
        fwd_b = fwd_sel(rs2_e_q, rd_m_q, regwrite_m_q, rd_w_q, regwrite_w_q);
    end

    // Conservative: rs2 is compared even if the D instruction does not read it
    assign lw_stall = load_e_q && (rd_e_q != 5'd0) && ((rd_e_q == Rs1D) || (rd_e_q == Rs2D));

    // A multi-cycle op in E must not be discarded while it is still running
    assign flush_e = (lw_stall || PCSrcE) && !stall_e;

    always_comb begin
        ForwardAE = FwdRf;
        ForwardBE = FwdRf;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b1;
        FlushE    = 1'b1;
        if (rst_n) begin
            ForwardAE = fwd_a;
            ForwardBE = fwd_b;
            StallF    = lw_stall || stall_e;
            StallD    = lw_stall || stall_e;
            StallE    = stall_e;
            FlushD    = PCSrcE;
            FlushE    = flush_e;
        end
    end

    // Shadow pipeline next state
    always_comb begin
        rs1_e_d      = rs1_e_q;
        rs2_e_d      = rs2_e_q;
        rd_e_d       = rd_e_q;
        regwrite_e_d = regwrite_e_q;
        load_e_d     = load_e_q;
        if (flush_e) begin
            rs1_e_d      = 5'd0;
            rs2_e_d      = 5'd0;
            rd_e_d       = 5'd0;
            regwrite_e_d = 1'b0;
            load_e_d     = 1'b0;
        end else if (!stall_e) begin
            rs1_e_d      = Rs1D;
            rs2_e_d      = Rs2D;
            rd_e_d       = RdD;
            regwrite_e_d = RegWriteD;
            load_e_d     = load_d;
        end

        // E is held, so M receives a bubble instead of a duplicate
        rd_m_d       = rd_e_q;
        regwrite_m_d = regwrite_e_q;
        if (stall_e) begin
            regwrite_m_d = 1'b0;
        end

        rd_w_d       = rd_m_q;
        regwrite_w_d = regwrite_m_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rs1_e_q      <= 5'd0;
            rs2_e_q      <= 5'd0;
            rd_e_q       <= 5'd0;
            regwrite_e_q <= 1'b0;
            load_e_q     <= 1'b0;
            rd_m_q       <= 5'd0;
            regwrite_m_q <= 1'b0;
            rd_w_q       <= 5'd0;
            regwrite_w_q <= 1'b0;
        end else begin
            rs1_e_q      <= rs1_e_d;
            rs2_e_q      <= rs2_e_d;
            rd_e_q       <= rd_e_d;
            regwrite_e_q <= regwrite_e_d;
            load_e_q     <= load_e_d;
            rd_m_q       <= rd_m_d;
            regwrite_m_q <= regwrite_m_d;
            rd_w_q       <= rd_w_d;
            regwrite_w_q <= regwrite_w_d;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Testbench for hazard_unit. A driver issues one D-stage instruction per cycle and pushes the
// expected control outputs into a queue. The expectations come either from hand-derived
// constants (directed sequences) or from an instruction-level pipeline model. A separate
// monitor pops one expectation per cycle and compares it at the falling edge.

module tb_hazard_unit;

    localparam int unsigned Lat = 4;
`ifdef HAZARD_MULDIV_EN
    localparam bit MulEn = 1'b1;
`else
    localparam bit MulEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] Rs1D, Rs2D, RdD;
    logic       RegWriteD;
    logic [1:0] ResultSrcD;
    logic       MulD, PCSrcE;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, FlushD, FlushE;

    always #5 clk = ~clk;

    hazard_unit #(.MUL_LAT(Lat)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Rs1D      (Rs1D),
        .Rs2D      (Rs2D),
        .RdD       (RdD),
        .RegWriteD (RegWriteD),
        .ResultSrcD(ResultSrcD),
        .MulD      (MulD),
        .PCSrcE    (PCSrcE),
        .ForwardAE (ForwardAE),
        .ForwardBE (ForwardBE),
        .StallF    (StallF),
        .StallD    (StallD),
        .StallE    (StallE),
        .FlushD    (FlushD),
        .FlushE    (FlushE)
    );

    typedef struct packed {
        logic [1:0] fa;
        logic [1:0] fb;
        logic       sf;
        logic       sd;
        logic       se;
        logic       fd;
        logic       fe;
    } exp_t;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       wr;
        logic       load;
        logic       mul;
    } ins_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    failures = 0;

    // Instruction-level model: which instruction sits in each stage, and for how long E is busy
    ins_t e_s, m_s, w_s;
    int   e_age;
    ins_t d_in;
    logic pc_in, rst_in;

    localparam ins_t Nop = '0;
    localparam exp_t Z   = '0;

    function automatic ins_t mk(input int rs1, input int rs2, input int rd, input bit wr,
                                input bit load, input bit mul);
        ins_t i;
        i.rs1 = 5'(rs1);
        i.rs2 = 5'(rs2);
        i.rd = 5'(rd);
        i.wr = wr;
        i.load = load;
        i.mul = mul;
        return i;
    endfunction

    function automatic exp_t ex(input int fa, input int fb, input bit sf, input bit sd,
                                input bit se, input bit fd, input bit fe);
        exp_t e;
        e.fa = 2'(fa);
        e.fb = 2'(fb);
        e.sf = sf;
        e.sd = sd;
        e.se = se;
        e.fd = fd;
        e.fe = fe;
        return e;
    endfunction

    function automatic logic [1:0] src_of(input logic [4:0] r);
        if (m_s.wr && m_s.rd != 0 && m_s.rd == r) return 2'd2;
        if (w_s.wr && w_s.rd != 0 && w_s.rd == r) return 2'd1;
        return 2'd0;
    endfunction

    function automatic bit mul_busy();
        return MulEn && e_s.mul && (e_age < int'(Lat) - 1);
    endfunction

    function automatic bit load_use();
        return e_s.load && e_s.rd != 0 && (e_s.rd == d_in.rs1 || e_s.rd == d_in.rs2);
    endfunction

    function automatic exp_t predict();
        bit busy, lu;
        if (!rst_in) return ex(0, 0, 0, 0, 0, 1, 1);
        busy = mul_busy();
        lu = load_use();
        return ex(int'(src_of(e_s.rs1)), int'(src_of(e_s.rs2)), lu || busy, lu || busy, busy,
                  pc_in, (lu || pc_in) && !busy);
    endfunction

    // Move instructions one stage along, as the clock edge just did
    task automatic advance();
        bit busy, flush;
        if (!rst_in) begin
            e_s = Nop;
            m_s = Nop;
            w_s = Nop;
            e_age = 0;
        end else begin
            busy = mul_busy();
            flush = (load_use() || pc_in) && !busy;
            w_s = m_s;
            m_s = busy ? Nop : e_s;
            if (flush) e_s = Nop;
            else if (!busy) e_s = d_in;
            e_age = busy ? e_age + 1 : 0;
        end
    endtask

    task automatic step(input ins_t d, input logic pc, input logic rstn, input bit hand,
                        input exp_t he, input string nm);
        int k;
        @(posedge clk);
        #1;
        advance();
        d_in = d;
        pc_in = pc;
        rst_in = rstn;
        Rs1D = d.rs1;
        Rs2D = d.rs2;
        RdD = d.rd;
        RegWriteD = d.wr;
        k = $urandom_range(0, 2);
        ResultSrcD = d.load ? 2'b01 : (k == 0 ? 2'b00 : (k == 1 ? 2'b10 : 2'b11));
        MulD = d.mul;
        PCSrcE = pc;
        rst_n = rstn;
        exp_q.push_back(hand ? he : predict());
        name_q.push_back(nm);
    endtask

    task automatic chk(input ins_t d, input logic pc, input logic rstn, input exp_t he,
                       input string nm);
        step(d, pc, rstn, 1'b1, he, nm);
    endtask

    task automatic pad(input int n);
        for (int i = 0; i < n; i++) step(Nop, 1'b0, 1'b1, 1'b0, Z, "pad");
    endtask

    // Monitor: one output set per cycle, compared away from the rising edge
    initial begin
        exp_t  e, got;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                nm = name_q.pop_front();
                got = {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE};
                checks++;
                if (got !== e) begin
                    failures++;
                    $display("FAIL %s: got fa=%b fb=%b sf=%b sd=%b se=%b fd=%b fe=%b, want fa=%b fb=%b sf=%b sd=%b se=%b fd=%b fe=%b",
                             nm, got.fa, got.fb, got.sf, got.sd, got.se, got.fd, got.fe,
                             e.fa, e.fb, e.sf, e.sd, e.se, e.fd, e.fe);
                end
            end
        end
    end

    initial begin
        ins_t d;
        rst_n = 1'b0;
        Rs1D = '0;
        Rs2D = '0;
        RdD = '0;
        RegWriteD = 1'b0;
        ResultSrcD = 2'b00;
        MulD = 1'b0;
        PCSrcE = 1'b0;
        e_s = Nop;
        m_s = Nop;
        w_s = Nop;
        e_age = 0;
        d_in = Nop;
        pc_in = 1'b0;
        rst_in = 1'b0;

        chk(Nop, 1'b0, 1'b0, ex(0, 0, 0, 0, 0, 1, 1), "reset_forced");
        chk(Nop, 1'b0, 1'b1, Z, "reset_state");
        pad(3);

        // add x5 -> sub uses x5 (M) -> or uses x5 (W)
        chk(mk(1, 2, 5, 1, 0, 0), 1'b0, 1'b1, Z, "alu_issue");
        chk(mk(5, 3, 7, 1, 0, 0), 1'b0, 1'b1, Z, "alu_dep_in_d");
        chk(mk(5, 0, 8, 1, 0, 0), 1'b0, 1'b1, ex(2, 0, 0, 0, 0, 0, 0), "alu_fwd_m");
        chk(Nop, 1'b0, 1'b1, ex(1, 0, 0, 0, 0, 0, 0), "alu_fwd_w");
        chk(Nop, 1'b0, 1'b1, Z, "alu_drain");
        pad(3);

        // Writes and loads to x0 never forward or stall
        chk(mk(1, 1, 0, 1, 0, 0), 1'b0, 1'b1, Z, "x0_write");
        chk(mk(0, 0, 0, 1, 1, 0), 1'b0, 1'b1, Z, "x0_load");
        chk(mk(0, 0, 9, 1, 0, 0), 1'b0, 1'b1, Z, "x0_use1");
        chk(Nop, 1'b0, 1'b1, Z, "x0_use2");
        chk(Nop, 1'b0, 1'b1, Z, "x0_use3");
        pad(3);

        // lw x6 then consumer with rs2 = x6
        chk(mk(1, 0, 6, 1, 1, 0), 1'b0, 1'b1, Z, "lu_issue");
        chk(mk(4, 6, 10, 1, 0, 0), 1'b0, 1'b1, ex(0, 0, 1, 1, 0, 0, 1), "lu_stall");
        chk(mk(4, 6, 10, 1, 0, 0), 1'b0, 1'b1, Z, "lu_bubble");
        chk(Nop, 1'b0, 1'b1, ex(0, 1, 0, 0, 0, 0, 0), "lu_fwd_w");
        pad(3);

        // Taken branch: flushed instruction must not forward later
        chk(mk(1, 0, 11, 1, 0, 0), 1'b0, 1'b1, Z, "br_issue");
        chk(mk(2, 0, 12, 1, 0, 0), 1'b1, 1'b1, ex(0, 0, 0, 0, 0, 1, 1), "br_taken");
        chk(mk(12, 12, 13, 1, 0, 0), 1'b0, 1'b1, Z, "br_bubble");
        chk(Nop, 1'b0, 1'b1, Z, "br_no_fwd");
        pad(3);

        // Load-use coinciding with a taken branch
        chk(mk(1, 0, 6, 1, 1, 0), 1'b0, 1'b1, Z, "lub_issue");
        chk(mk(6, 0, 14, 1, 0, 0), 1'b1, 1'b1, ex(0, 0, 1, 1, 0, 1, 1), "lub_both");
        chk(Nop, 1'b0, 1'b1, Z, "lub_after");
        pad(3);

        // Reset during a load-use stall
        chk(mk(1, 0, 6, 1, 1, 0), 1'b0, 1'b1, Z, "rlu_issue");
        chk(mk(6, 6, 15, 1, 0, 0), 1'b0, 1'b1, ex(0, 0, 1, 1, 0, 0, 1), "rlu_stall");
        chk(mk(6, 6, 15, 1, 0, 0), 1'b0, 1'b0, ex(0, 0, 0, 0, 0, 1, 1), "rlu_forced");
        chk(mk(6, 6, 15, 1, 0, 0), 1'b0, 1'b1, Z, "rlu_release");
        pad(3);

`ifdef HAZARD_MULDIV_EN
        // mul x13 occupies E for Lat cycles, dependent gets M forwarding afterwards
        chk(mk(1, 2, 13, 1, 0, 1), 1'b0, 1'b1, Z, "mul_issue");
        chk(mk(13, 0, 14, 1, 0, 0), 1'b0, 1'b1, ex(0, 0, 1, 1, 1, 0, 0), "mul_stall1");
        chk(mk(13, 0, 14, 1, 0, 0), 1'b0, 1'b1, ex(0, 0, 1, 1, 1, 0, 0), "mul_stall2");
        chk(mk(13, 0, 14, 1, 0, 0), 1'b0, 1'b1, ex(0, 0, 1, 1, 1, 0, 0), "mul_stall3");
        chk(mk(13, 0, 14, 1, 0, 0), 1'b0, 1'b1, Z, "mul_done");
        chk(Nop, 1'b0, 1'b1, ex(2, 0, 0, 0, 0, 0, 0), "mul_fwd_m");
        pad(3);

        // Reset during the mul stall abandons it
        chk(mk(1, 2, 13, 1, 0, 1), 1'b0, 1'b1, Z, "mulr_issue");
        chk(mk(13, 0, 14, 1, 0, 0), 1'b0, 1'b1, ex(0, 0, 1, 1, 1, 0, 0), "mulr_stall");
        chk(mk(13, 0, 14, 1, 0, 0), 1'b0, 1'b0, ex(0, 0, 0, 0, 0, 1, 1), "mulr_forced");
        chk(mk(13, 0, 14, 1, 0, 0), 1'b0, 1'b1, Z, "mulr_release");
        chk(Nop, 1'b0, 1'b1, Z, "mulr_after");
        pad(3);
`endif

        // Random traffic over a small register set to provoke hazards
        for (int i = 0; i < 1500; i++) begin
            d = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   bit'($urandom_range(0, 1)), $urandom_range(0, 2) == 0,
                   $urandom_range(0, 4) == 0);
            step(d, $urandom_range(0, 5) == 0, $urandom_range(0, 49) != 0, 1'b0, Z, "random");
        end

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
